// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes,
// datapath select codes and the decoded opcode class.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } op_class_e;

endpackage

// File: rtl/opcode_classifier.sv
// Purely combinational opcode decode: maps instruction[6:0] to an opcode class
// and flags anything outside the supported base set as illegal.
module opcode_classifier
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_e  class_o,
    output logic       illegal_o
);

    always_comb begin
        class_o   = CLS_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_R:      class_o = CLS_R;
            OP_I:      class_o = CLS_I;
            OP_LOAD:   class_o = CLS_LOAD;
            OP_STORE:  class_o = CLS_STORE;
            OP_BRANCH: class_o = CLS_BRANCH;
            OP_JAL:    class_o = CLS_JAL;
            OP_JALR:   class_o = CLS_JALR;
            OP_LUI:    class_o = CLS_LUI;
            OP_AUIPC:  class_o = CLS_AUIPC;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, bounds memory
// waits with a cycle counter and parks in TRAP until reset.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic [1:0] wb_sel,
    output logic       branch_en,
    output logic       instr_done,
    output logic       trap,
    output logic [2:0] state_o
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e    state_q, state_d;
    op_class_e class_q, class_d;
    logic [7:0] wait_q, wait_d;

    op_class_e dec_class;
    logic      dec_illegal;
    logic      wait_last;

    opcode_classifier u_classifier (
        .opcode_i  (opcode),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    assign wait_last = (wait_q == WAIT_LAST);
    assign state_o   = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            class_q <= CLS_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
        end
    end

    // Memory handshake: mem_req stays high from the first FETCH/MEM cycle until
    // the cycle mem_ready is seen high; that cycle completes the access.
    // wait_d falls back to zero on every state change, so entry clears it.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        wait_d  = '0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_last) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                class_d = dec_illegal ? CLS_NONE : dec_class;
                state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH:          state_d = ST_FETCH;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (wait_last) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        pc_src       = PC_PLUS4;
        alu_op       = ALU_ADD;
        alu_src      = 1'b0;
        wb_sel       = WB_ALU;
        branch_en    = 1'b0;
        instr_done   = 1'b0;
        trap         = 1'b0;
        // Reset masks every output so nothing leaks while the state is forced.
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_PLUS4;
                    end
                end
                ST_EXEC: begin
                    case (class_q)
                        CLS_R: alu_op = ALU_FUNCT;
                        CLS_I: begin
                            alu_op  = ALU_FUNCT;
                            alu_src = 1'b1;
                        end
                        CLS_LOAD, CLS_STORE, CLS_LUI, CLS_AUIPC: begin
                            alu_op  = ALU_ADD;
                            alu_src = 1'b1;
                        end
                        CLS_BRANCH: begin
                            alu_op     = ALU_SUB;
                            branch_en  = 1'b1;
                            pc_src     = PC_BRANCH;
                            instr_done = 1'b1;
                        end
                        CLS_JAL, CLS_JALR: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (class_q == CLS_STORE);
                    instr_done   = mem_ready && (class_q == CLS_STORE);
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    if (class_q == CLS_LOAD) begin
                        wb_sel = WB_MEM;
                    end else if (class_q == CLS_JAL || class_q == CLS_JALR) begin
                        wb_sel = WB_PC4;
                    end
                end
                ST_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
